// File: rtl/risc16_regfile_port_ctrl_pkg.sv
// Shared constants, command opcodes and FSM state encodings for the
// RiSC-16 register-file port controller.
package risc16_regfile_port_ctrl_pkg;

  localparam int WORD_LENGTH  = 16;
  localparam int REG_ADDR_LEN = 3;
  localparam int REG_NUM      = 8;

  // One extra bit so the terminal compare on the last register cannot wrap.
  localparam int CNT_LEN = REG_ADDR_LEN + 1;
  localparam logic [CNT_LEN-1:0] CLEAR_LAST = CNT_LEN'(REG_NUM - 1);

  typedef enum logic [1:0] {
    OP_RSVD  = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_CLEAR,
    ST_RESP
  } state_e;

endpackage

// File: rtl/risc16_regfile_port_ctrl_if.sv
// Command and response valid/ready channels of the register-file port
// controller; master is the command issuer, slave is the controller.
interface risc16_regfile_port_ctrl_if;
  import risc16_regfile_port_ctrl_pkg::*;

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [1:0]              cmd_op;
  logic [REG_ADDR_LEN-1:0] cmd_addr;
  logic [WORD_LENGTH-1:0]  cmd_data;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [WORD_LENGTH-1:0]  rsp_data;
  logic [REG_ADDR_LEN-1:0] rsp_addr;
  logic                    rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
  );

endinterface

// File: rtl/risc16_regfile_port_ctrl.sv
// Command-driven initiator for the RiSC-16 register file read port 1 and
// write port; every output is registered from the next-state logic.
module risc16_regfile_port_ctrl
  import risc16_regfile_port_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  risc16_regfile_port_ctrl_if.slave bus,
  output logic                    busy,
  output logic [REG_ADDR_LEN-1:0] rf_addr1,
  input  logic [WORD_LENGTH-1:0]  rf_src1,
  output logic [REG_ADDR_LEN-1:0] rf_addrT,
  output logic [WORD_LENGTH-1:0]  rf_trgt,
  output logic                    rf_wen
);

  state_e                  r_state,    w_state_nxt;
  logic [REG_ADDR_LEN-1:0] r_addr,     w_addr_nxt;
  logic [WORD_LENGTH-1:0]  r_data,     w_data_nxt;
  logic [CNT_LEN-1:0]      r_cnt,      w_cnt_nxt;
  logic                    r_cmdReady, w_cmdReady_nxt;
  logic                    r_busy,     w_busy_nxt;
  logic                    r_rspValid, w_rspValid_nxt;
  logic [WORD_LENGTH-1:0]  r_rspData,  w_rspData_nxt;
  logic [REG_ADDR_LEN-1:0] r_rspAddr,  w_rspAddr_nxt;
  logic                    r_rspErr,   w_rspErr_nxt;
  logic                    r_wen,      w_wen_nxt;
  logic [REG_ADDR_LEN-1:0] r_addrT,    w_addrT_nxt;
  logic [WORD_LENGTH-1:0]  r_trgt,     w_trgt_nxt;
  logic [REG_ADDR_LEN-1:0] r_addr1,    w_addr1_nxt;
  op_e                     w_op;

  assign w_op = op_e'(bus.cmd_op);

  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_data_nxt     = r_data;
    w_cnt_nxt      = r_cnt;
    w_rspValid_nxt = 1'b0;
    w_rspData_nxt  = r_rspData;
    w_rspAddr_nxt  = r_rspAddr;
    w_rspErr_nxt   = r_rspErr;
    w_wen_nxt      = 1'b0;
    w_addrT_nxt    = '0;
    w_trgt_nxt     = '0;
    w_addr1_nxt    = '0;

    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid && r_cmdReady) begin
          w_addr_nxt = bus.cmd_addr;
          w_data_nxt = bus.cmd_data;
          case (w_op)
            OP_WRITE: begin
              w_state_nxt = ST_WRITE;
              // Register 0 is hardwired zero, so its write is never issued.
              if (bus.cmd_addr != '0) begin
                w_wen_nxt   = 1'b1;
                w_addrT_nxt = bus.cmd_addr;
                w_trgt_nxt  = bus.cmd_data;
              end
            end
            OP_READ: begin
              w_state_nxt = ST_READ;
              w_addr1_nxt = bus.cmd_addr;
            end
            OP_CLEAR: begin
              w_state_nxt = ST_CLEAR;
              w_cnt_nxt   = CNT_LEN'(1);
              w_wen_nxt   = 1'b1;
              w_addrT_nxt = REG_ADDR_LEN'(1);
            end
            default: begin
              w_state_nxt    = ST_RESP;
              w_rspValid_nxt = 1'b1;
              w_rspData_nxt  = '0;
              w_rspAddr_nxt  = bus.cmd_addr;
              w_rspErr_nxt   = 1'b1;
            end
          endcase
        end
      end
      ST_WRITE: begin
        w_state_nxt    = ST_RESP;
        w_rspValid_nxt = 1'b1;
        w_rspAddr_nxt  = r_addr;
        w_rspErr_nxt   = (r_addr == '0);
        w_rspData_nxt  = (r_addr == '0) ? '0 : r_data;
      end
      ST_READ: begin
        w_state_nxt    = ST_RESP;
        w_rspValid_nxt = 1'b1;
        w_rspData_nxt  = rf_src1;
        w_rspAddr_nxt  = r_addr;
        w_rspErr_nxt   = 1'b0;
      end
      ST_CLEAR: begin
        if (r_cnt == CLEAR_LAST) begin
          w_state_nxt    = ST_RESP;
          w_rspValid_nxt = 1'b1;
          w_rspData_nxt  = WORD_LENGTH'(REG_NUM - 1);
          w_rspAddr_nxt  = '0;
          w_rspErr_nxt   = 1'b0;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
          w_wen_nxt   = 1'b1;
          w_addrT_nxt = REG_ADDR_LEN'(r_cnt + 1'b1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) w_state_nxt = ST_IDLE;
        else               w_rspValid_nxt = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_cmdReady_nxt = (w_state_nxt == ST_IDLE);
    w_busy_nxt     = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_data     <= '0;
      r_cnt      <= '0;
      r_cmdReady <= 1'b0;
      r_busy     <= 1'b0;
      r_rspValid <= 1'b0;
      r_rspData  <= '0;
      r_rspAddr  <= '0;
      r_rspErr   <= 1'b0;
      r_wen      <= 1'b0;
      r_addrT    <= '0;
      r_trgt     <= '0;
      r_addr1    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_data     <= w_data_nxt;
      r_cnt      <= w_cnt_nxt;
      r_cmdReady <= w_cmdReady_nxt;
      r_busy     <= w_busy_nxt;
      r_rspValid <= w_rspValid_nxt;
      r_rspData  <= w_rspData_nxt;
      r_rspAddr  <= w_rspAddr_nxt;
      r_rspErr   <= w_rspErr_nxt;
      r_wen      <= w_wen_nxt;
      r_addrT    <= w_addrT_nxt;
      r_trgt     <= w_trgt_nxt;
      r_addr1    <= w_addr1_nxt;
    end
  end

  assign bus.cmd_ready = r_cmdReady;
  assign bus.rsp_valid = r_rspValid;
  assign bus.rsp_data  = r_rspData;
  assign bus.rsp_addr  = r_rspAddr;
  assign bus.rsp_err   = r_rspErr;
  assign busy          = r_busy;
  assign rf_wen        = r_wen;
  assign rf_addrT      = r_addrT;
  assign rf_trgt       = r_trgt;
  assign rf_addr1      = r_addr1;

endmodule

// File: tb/tb_risc16_regfile_port_ctrl.sv
// Directed bench for risc16_regfile_port_ctrl with a behavioural register
// file and a response scoreboard fed from a shadow register model.
module tb_risc16_regfile_port_ctrl;
  import risc16_regfile_port_ctrl_pkg::*;

  typedef struct packed {
    logic [WORD_LENGTH-1:0]  data;
    logic [REG_ADDR_LEN-1:0] addr;
    logic                    err;
  } rspExp_t;

  typedef struct packed {
    logic [REG_ADDR_LEN-1:0] addr;
    logic [WORD_LENGTH-1:0]  data;
  } wrEvt_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    busy;
  logic [REG_ADDR_LEN-1:0] rf_addr1;
  logic [WORD_LENGTH-1:0]  rf_src1;
  logic [REG_ADDR_LEN-1:0] rf_addrT;
  logic [WORD_LENGTH-1:0]  rf_trgt;
  logic                    rf_wen;

  logic [WORD_LENGTH-1:0]  rfMem [REG_NUM] = '{default: '0};
  logic [WORD_LENGTH-1:0]  model [REG_NUM];
  rspExp_t                 sb [$];
  wrEvt_t                  wrLog [$];
  int                      rdCount = 0;
  int                      nChecks = 0;
  int                      nFails  = 0;

  risc16_regfile_port_ctrl_if bus ();

  risc16_regfile_port_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .rf_addr1 (rf_addr1),
    .rf_src1  (rf_src1),
    .rf_addrT (rf_addrT),
    .rf_trgt  (rf_trgt),
    .rf_wen   (rf_wen)
  );

  always #5 clk = ~clk;

  // Behavioural RiSC-16 register file: combinational read, r0 reads zero.
  assign rf_src1 = (rf_addr1 == '0) ? '0 : rfMem[rf_addr1];
  always @(posedge clk) begin
    if (rf_wen && rf_addrT != '0) rfMem[rf_addrT] <= rf_trgt;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to the next falling edge and log register-file port activity.
  task automatic tick();
    @(negedge clk);
    if (rf_wen === 1'b1) wrLog.push_back({rf_addrT, rf_trgt});
    if (rf_addr1 !== '0) rdCount++;
  endtask

  task automatic applyStimulus(input op_e op, input logic [REG_ADDR_LEN-1:0] addr,
                               input logic [WORD_LENGTH-1:0] data);
    int      n = 0;
    rspExp_t e;
    while (bus.cmd_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput($sformatf("cmd_ready before op %0d addr %0d", op, addr), 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    case (op)
      OP_WRITE: begin
        if (addr == '0) e = '{data: '0, addr: addr, err: 1'b1};
        else begin
          e = '{data: data, addr: addr, err: 1'b0};
          model[addr] = data;
        end
      end
      OP_READ:  e = '{data: model[addr], addr: addr, err: 1'b0};
      OP_CLEAR: begin
        e = '{data: WORD_LENGTH'(REG_NUM - 1), addr: '0, err: 1'b0};
        for (int i = 1; i < REG_NUM; i++) model[i] = '0;
      end
      default:  e = '{data: '0, addr: addr, err: 1'b1};
    endcase
    sb.push_back(e);
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;
  endtask

  // Called on the falling edge of cycle N+1; latency counts from there.
  task automatic waitResponse(input string tag, input int expLat, input int holdCycles);
    int      lat = 1;
    rspExp_t e = '0;
    rspExp_t held;
    logic    stable = 1'b1;
    while (bus.rsp_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    checkOutput({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, " scoreboard entry"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) e = sb.pop_front();
    checkOutput({tag, " rsp_data"}, 32'(bus.rsp_data), 32'(e.data));
    checkOutput({tag, " rsp_addr"}, 32'(bus.rsp_addr), 32'(e.addr));
    checkOutput({tag, " rsp_err"}, 32'(bus.rsp_err), 32'(e.err));
    held = {bus.rsp_data, bus.rsp_addr, bus.rsp_err};
    for (int i = 0; i < holdCycles; i++) begin
      tick();
      if ({bus.rsp_data, bus.rsp_addr, bus.rsp_err} !== held ||
          bus.rsp_valid !== 1'b1 || bus.cmd_ready !== 1'b0) stable = 1'b0;
    end
    if (holdCycles > 0) checkOutput({tag, " held stable"}, 32'(stable), 32'd1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    checkOutput({tag, " rsp_valid drop"}, 32'(bus.rsp_valid), 32'd0);
    checkOutput({tag, " cmd_ready return"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    logic quiet;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < REG_NUM; i++) model[i] = '0;

    // Reset and release.
    #2 rst = 1'b0;
    tick();
    tick();
    checkOutput("reset cmd_ready", 32'(bus.cmd_ready), 32'd0);
    checkOutput("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset rf_wen", 32'(rf_wen), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("cmd_ready before first edge", 32'(bus.cmd_ready), 32'd0);
    tick();
    checkOutput("cmd_ready after release", 32'(bus.cmd_ready), 32'd1);

    // WRITE r1.
    wrLog.delete();
    applyStimulus(OP_WRITE, 3'd1, 16'h1234);
    checkOutput("write r1 busy", 32'(busy), 32'd1);
    waitResponse("write r1", 2, 0);
    checkOutput("write r1 wen cycles", 32'(wrLog.size()), 32'd1);
    if (wrLog.size() > 0) begin
      checkOutput("write r1 rf_addrT", 32'(wrLog[0].addr), 32'd1);
      checkOutput("write r1 rf_trgt", 32'(wrLog[0].data), 32'h1234);
    end

    // READ r1 with the consumer stalling for five cycles.
    rdCount = 0;
    applyStimulus(OP_READ, 3'd1, 16'h0000);
    checkOutput("read r1 rf_addr1", 32'(rf_addr1), 32'd1);
    waitResponse("read r1", 2, 5);
    checkOutput("read r1 addr1 cycles", 32'(rdCount), 32'd1);

    // WRITE r0 is rejected, READ r0 returns zero.
    wrLog.delete();
    applyStimulus(OP_WRITE, 3'd0, 16'h2356);
    waitResponse("write r0", 2, 0);
    checkOutput("write r0 wen cycles", 32'(wrLog.size()), 32'd0);
    applyStimulus(OP_READ, 3'd0, 16'h0000);
    waitResponse("read r0", 2, 0);

    // Fill r1..r7, CLEAR, then read everything back.
    for (int i = 1; i < REG_NUM; i++) begin
      applyStimulus(OP_WRITE, REG_ADDR_LEN'(i), 16'hFFFF);
      waitResponse($sformatf("fill r%0d", i), 2, 0);
    end
    wrLog.delete();
    applyStimulus(OP_CLEAR, 3'd0, 16'h0000);
    waitResponse("clear", 8, 0);
    checkOutput("clear wen cycles", 32'(wrLog.size()), 32'(REG_NUM - 1));
    quiet = 1'b1;
    for (int i = 0; i < wrLog.size(); i++) begin
      if (wrLog[i].addr !== REG_ADDR_LEN'(i + 1) || wrLog[i].data !== '0) quiet = 1'b0;
    end
    checkOutput("clear write sequence", 32'(quiet), 32'd1);
    for (int i = 1; i < REG_NUM; i++) begin
      applyStimulus(OP_READ, REG_ADDR_LEN'(i), 16'h0000);
      waitResponse($sformatf("post-clear read r%0d", i), 2, 0);
    end

    // Reset during the third CLEAR write.
    for (int i = 1; i < REG_NUM; i++) begin
      applyStimulus(OP_WRITE, REG_ADDR_LEN'(i), 16'hFFFF);
      waitResponse($sformatf("refill r%0d", i), 2, 0);
    end
    applyStimulus(OP_CLEAR, 3'd0, 16'h0000);
    tick();
    tick();
    checkOutput("third clear write wen", 32'(rf_wen), 32'd1);
    checkOutput("third clear write addrT", 32'(rf_addrT), 32'd3);
    rst = 1'b0;
    #1;
    checkOutput("mid-clear reset rf_wen", 32'(rf_wen), 32'd0);
    checkOutput("mid-clear reset rf_addrT", 32'(rf_addrT), 32'd0);
    checkOutput("mid-clear reset busy", 32'(busy), 32'd0);
    checkOutput("mid-clear reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    sb.delete();
    for (int i = 3; i < REG_NUM; i++) model[i] = 16'hFFFF;
    tick();
    rst = 1'b1;
    tick();
    checkOutput("cmd_ready after mid-clear reset", 32'(bus.cmd_ready), 32'd1);
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.rsp_valid !== 1'b0 || rf_wen !== 1'b0) quiet = 1'b0;
    end
    checkOutput("no response after reset", 32'(quiet), 32'd1);
    for (int i = 1; i < REG_NUM; i++) begin
      applyStimulus(OP_READ, REG_ADDR_LEN'(i), 16'h0000);
      waitResponse($sformatf("after-reset read r%0d", i), 2, 0);
    end

    // Reserved opcode: immediate error, no register-file traffic.
    wrLog.delete();
    rdCount = 0;
    applyStimulus(OP_RSVD, 3'd5, 16'hABCD);
    waitResponse("reserved op", 1, 0);
    checkOutput("reserved op wen cycles", 32'(wrLog.size()), 32'd0);
    checkOutput("reserved op addr1 cycles", 32'(rdCount), 32'd0);

    // Consumer ready ahead of the response.
    bus.rsp_ready = 1'b1;
    applyStimulus(OP_READ, 3'd5, 16'h0000);
    waitResponse("ready-early read r5", 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/risc16_regfile_port_ctrl.md
Name: risc16_regfile_port_ctrl

Overview:
- Command-driven initiator for the RiSC-16 register file's read port 1 and write port.
- Accepts write, read and clear commands over a valid/ready command channel.
- Sequences the matching register-file accesses and returns exactly one response per command over a valid/ready response channel.
- Used as the debug/loader front end that presets and inspects architectural registers without the datapath.

Parameters:
- WORD_LENGTH, 16: register data width.
- REG_ADDR_LEN, 3: register address width.
- REG_NUM, 8: number of registers. Register 0 is hardwired zero.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  00 reserved, 01 WRITE, 10 READ, 11 CLEAR.
- cmd_addr  in  REG_ADDR_LEN  target register.
- cmd_data  in  WORD_LENGTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  WORD_LENGTH  read value, write echo, or clear count.
- rsp_addr  out  REG_ADDR_LEN  address of the command being answered.
- rsp_err  out  1  command rejected.
- busy  out  1  FSM not in IDLE.
- rf_addr1  out  REG_ADDR_LEN  to register file addr1.
- rf_src1  in  WORD_LENGTH  from register file src1; combinational read of reg[rf_addr1].
- rf_addrT  out  REG_ADDR_LEN  to register file addrT.
- rf_trgt  out  WORD_LENGTH  to register file trgt.
- rf_wen  out  1  to register file wen; the write commits on the rising clk edge while high.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE; the clear counter goes to 0.
  - All outputs go to 0, including cmd_ready and rf_wen.
  - cmd_ready rises in the first cycle after rst is released.
- States: IDLE, WRITE, READ, CLEAR, RESP. All outputs are registered.
- IDLE:
  - cmd_ready is 1.
  - A handshake (cmd_valid & cmd_ready at edge N) latches op, addr and data.
  - Next state by op: WRITE → WRITE; READ → READ; CLEAR → CLEAR.
  - op 00 → RESP with rsp_err=1 and rsp_data=0.
- cmd_ready is 0 in every state except IDLE. No command is accepted while a response is pending.
- WRITE:
  - For one cycle (N+1): rf_wen=1, rf_addrT=addr, rf_trgt=data.
  - Then RESP with rsp_data=data and rsp_err=0.
  - WRITE to addr 0 is suppressed: rf_wen stays 0, and RESP returns rsp_err=1 with rsp_data=0.
- READ:
  - For one cycle (N+1), rf_addr1=addr.
  - rf_src1 is sampled at the end of that cycle into rsp_data.
  - Then RESP with rsp_err=0.
  - READ of addr 0 is legal and returns 0.
- CLEAR:
  - A counter walks 1..REG_NUM-1, one write per cycle (cycles N+1..N+REG_NUM-1).
  - Each cycle: rf_wen=1, rf_addrT=counter, rf_trgt=0.
  - After the last register, go to RESP with rsp_data=REG_NUM-1, rsp_addr=0, rsp_err=0.
  - The counter is REG_ADDR_LEN+1 bits wide so the terminal compare cannot wrap.
- RESP:
  - rsp_valid=1; rsp_data, rsp_addr and rsp_err are held stable until rsp_ready.
  - On the edge where rsp_valid & rsp_ready, go to IDLE and drop rsp_valid.
  - cmd_ready returns to 1 in the next cycle (one bubble per command).
- Latency from the accept edge N to rsp_valid:
  - WRITE and READ: rsp_valid at N+2.
  - CLEAR: rsp_valid at N+REG_NUM (N+8 at default).
  - Reserved op: rsp_valid at N+1.
- Outside WRITE and CLEAR, rf_wen, rf_addrT and rf_trgt are 0. Outside READ, rf_addr1 is 0.
- Reset asserted mid-operation (including mid-CLEAR):
  - rf_wen drops immediately; the remaining registers are left untouched.
  - No response is issued, and any pending response is discarded.
- rsp_ready held high in advance is legal: the response completes in its first RESP cycle.
- busy = (state != IDLE).

Decomposition:
- Shared defines header: cmd_op encodings (OP_RSVD, OP_WRITE, OP_READ, OP_CLEAR) and FSM state encodings.
- No sub-module. The block is a single FSM plus a clear counter.
- Benches instantiate it alongside RiSC16_registerFile with its rf_* ports wired directly to addr1/src1/addrT/trgt/wen.

Test Plan:
- Reset:
  - Stimulus: assert rst low mid-cycle.
  - Required: all outputs 0 asynchronously; cmd_ready=1 one cycle after release.
- WRITE addr 1 data 16'h1234:
  - Required: rf_wen=1 for exactly one cycle with rf_addrT=1 and rf_trgt=16'h1234.
  - Required: rsp_valid at N+2 with rsp_data=16'h1234 and rsp_err=0.
- READ addr 1 after that write:
  - Required: rf_addr1=1 for one cycle; rsp_data=16'h1234 at N+2.
  - Then, with rsp_ready held low for 5 cycles: response stable throughout, and cmd_ready=0 throughout.
- WRITE addr 0 data 16'h2356:
  - Required: rf_wen never asserts; rsp_err=1 and rsp_data=0.
  - A following READ addr 0 returns 0.
- CLEAR after writing 16'hFFFF to r1..r7:
  - Required: 7 consecutive rf_wen cycles with rf_addrT 1..7 and rf_trgt=0; rsp_data=7 at N+8.
  - Follow-up READs of r1..r7 all return 0.
- Reset mid-operation and reserved op:
  - Stimulus: assert rst at the 3rd CLEAR write.
  - Required: rf_wen drops immediately, no response issued, r4..r7 keep 16'hFFFF.
  - Stimulus: issue cmd_op=00.
  - Required: rsp_err=1 at N+1 and no register-file activity.
